// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   localparam int unsigned PC_STEP          = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_perf_ctr.sv
// Saturating fetch and stall event counters for the fetch stage.
module fetch_perf_ctr (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_inc,
   input  logic        stall_inc,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_stall_cnt
);

   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Next count: increment on event, stick at all-ones.
   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (fetch_inc && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_d = fetch_cnt_q + 32'd1;
      if (stall_inc && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
   end

   // Counter registers, cleared by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_cnt_q <= 32'd0;
         stall_cnt_q <= 32'd0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC sequencing, redirect/stall/halt control and IF/ID register.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int unsigned IMEM_WORDS = 128
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rd,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4,
   output logic        if_valid,
   output logic        halted,
   output logic        misalign
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_stall_cnt
`endif
);

   // Memory depth is the memory's concern; addresses past it simply alias.
   logic unused_imem_words;
   assign unused_imem_words = (IMEM_WORDS > 0);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  ifpc_q, ifpc_d;
   logic [31:0]  ifpc4_q, ifpc4_d;
   logic         valid_q, valid_d;
   logic         misalign_q, misalign_d;
   logic [31:0]  pc_plus4;

   assign pc_plus4 = pc_q + 32'(PC_STEP);

   // Next-state logic: redirect has priority over halt, halt over stall.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      ifpc_d     = ifpc_q;
      ifpc4_d    = ifpc4_q;
      valid_d    = valid_q;
      misalign_d = misalign_q;
      unique case (state_q)
         BOOT: begin
            state_d = RUN;
            valid_d = 1'b0;
         end
         RUN, HALT: begin
            if (redirect_valid) begin
               state_d    = RUN;
               pc_d       = {redirect_pc[31:2], 2'b00};
               valid_d    = 1'b0;
               misalign_d = misalign_q | (redirect_pc[1:0] != 2'b00);
            end else if (state_q == HALT) begin
               valid_d = 1'b0;
            end else if (halt_req) begin
               state_d = HALT;
               valid_d = 1'b0;
            end else if (!stall) begin
               instr_d = imem_rd;
               ifpc_d  = pc_q;
               ifpc4_d = pc_plus4;
               valid_d = 1'b1;
               pc_d    = pc_plus4;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   // State and IF/ID registers, asynchronously cleared.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC;
         instr_q    <= 32'd0;
         ifpc_q     <= 32'd0;
         ifpc4_q    <= 32'd0;
         valid_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         ifpc_q     <= ifpc_d;
         ifpc4_q    <= ifpc4_d;
         valid_q    <= valid_d;
         misalign_q <= misalign_d;
      end
   end

   assign imem_addr   = {2'b00, pc_q[31:2]};
   assign if_instr    = instr_q;
   assign if_pc       = ifpc_q;
   assign if_pc_plus4 = ifpc4_q;
   assign if_valid    = valid_q;
   assign halted      = (state_q == HALT);
   assign misalign    = misalign_q;

`ifdef FETCH_PERF_EN
   logic fetch_inc;
   logic stall_inc;

   assign fetch_inc = (state_q == RUN) && !redirect_valid && !halt_req && !stall;
   assign stall_inc = (state_q == RUN) && stall && !redirect_valid;

   fetch_perf_ctr u_perf (
      .clk            (clk),
      .reset          (reset),
      .fetch_inc      (fetch_inc),
      .stall_inc      (stall_inc),
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_stall_cnt (perf_stall_cnt)
   );
`else
   // Counters not built in this configuration.
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch with a combinational instruction memory model.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rd;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic        if_valid;
   logic        halted;
   logic        misalign;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_stall_cnt;
`endif

   int checks = 0;
   int passes = 0;

   logic [31:0] mem [0:127];

   always #5 clk = ~clk;

   // Memory of 128 words; upper address bits alias.
   assign imem_rd = mem[imem_addr[6:0]];

   instr_fetch #(
      .RESET_PC   (32'h0000_0000),
      .IMEM_WORDS (128)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .imem_addr      (imem_addr),
      .imem_rd        (imem_rd),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_pc_plus4    (if_pc_plus4),
      .if_valid       (if_valid),
      .halted         (halted),
      .misalign       (misalign)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      stall = 0; redirect_valid = 0; redirect_pc = 0; halt_req = 0;
      reset = 1'b1;
      step();
      step();
      checks++; if (if_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", if_valid); else passes++;
      checks++; if (if_pc !== 32'd0) $display("FAIL reset_if_pc got %h want 0", if_pc); else passes++;
      checks++; if (imem_addr !== 32'd0) $display("FAIL reset_imem_addr got %h want 0", imem_addr); else passes++;
      checks++; if ({halted, misalign} !== 2'b00) $display("FAIL reset_flags got %b want 00", {halted, misalign}); else passes++;
   endtask

   task automatic test_boot_seq();
      logic [31:0] exp_instr [4];
      exp_instr[0] = 32'd11; exp_instr[1] = 32'd22; exp_instr[2] = 32'd33; exp_instr[3] = 32'd44;
      reset = 1'b0;
      step();
      checks++; if (if_valid !== 1'b0) $display("FAIL boot_valid got %b want 0", if_valid); else passes++;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (if_valid !== 1'b1 || if_pc !== 32'(4 * i) || if_instr !== exp_instr[i] ||
             if_pc_plus4 !== 32'(4 * i + 4))
            $display("FAIL seq_%0d got v=%b pc=%h instr=%0d pc4=%h want v=1 pc=%h instr=%0d",
                     i, if_valid, if_pc, if_instr, if_pc_plus4, 4 * i, exp_instr[i]);
         else passes++;
      end
   endtask

   task automatic test_stall();
      do_reset();
      step(); step(); step();   // BOOT, fetch pc 0, fetch pc 4 -> pc = 8
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (if_pc !== 32'd4 || imem_addr !== 32'd2 || if_instr !== 32'd22 || if_valid !== 1'b1)
            $display("FAIL stall_%0d got pc=%h addr=%h instr=%0d v=%b want pc=4 addr=2 instr=22 v=1",
                     i, if_pc, imem_addr, if_instr, if_valid);
         else passes++;
      end
      stall = 1'b0;
      step();
      checks++; if (if_pc !== 32'd8 || if_instr !== 32'd33)
         $display("FAIL stall_resume got pc=%h instr=%0d want pc=8 instr=33", if_pc, if_instr);
      else passes++;
   endtask

   task automatic test_redirect();
      redirect_valid = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
      step();
      redirect_valid = 1'b0; stall = 1'b0;
      checks++; if (if_valid !== 1'b0 || imem_addr !== 32'd16)
         $display("FAIL redirect_flush got v=%b addr=%h want v=0 addr=10", if_valid, imem_addr);
      else passes++;
      step();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_pc_plus4 !== 32'h44 || if_instr !== 32'h1010)
         $display("FAIL redirect_target got v=%b pc=%h pc4=%h instr=%h want 1 40 44 1010",
                  if_valid, if_pc, if_pc_plus4, if_instr);
      else passes++;
      checks++; if (misalign !== 1'b0) $display("FAIL redirect_aligned got %b want 0", misalign); else passes++;
   endtask

   task automatic test_misalign();
      redirect_valid = 1'b1; redirect_pc = 32'h42;
      step();
      redirect_valid = 1'b0;
      checks++; if (misalign !== 1'b1 || imem_addr !== 32'd16 || if_valid !== 1'b0)
         $display("FAIL misalign_set got m=%b addr=%h v=%b want 1 10 0", misalign, imem_addr, if_valid);
      else passes++;
      step(); step(); step();   // pc -> 0x4C
      redirect_valid = 1'b1; redirect_pc = 32'h80;
      step();
      redirect_valid = 1'b0;
      checks++; if (misalign !== 1'b1 || imem_addr !== 32'd32)
         $display("FAIL misalign_sticky got m=%b addr=%h want 1 20", misalign, imem_addr);
      else passes++;
   endtask

   task automatic test_halt();
      halt_req = 1'b1;
      step();
      halt_req = 1'b0;
      checks++; if (halted !== 1'b1 || if_valid !== 1'b0)
         $display("FAIL halt_enter got h=%b v=%b want 1 0", halted, if_valid);
      else passes++;
      for (int i = 0; i < 10; i++) begin
         stall = i[0];
         step();
         checks++;
         if (halted !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 32'd32)
            $display("FAIL halt_hold_%0d got h=%b v=%b addr=%h want 1 0 20", i, halted, if_valid, imem_addr);
         else passes++;
      end
      stall = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'h0;
      step();
      redirect_valid = 1'b0;
      checks++; if (halted !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 32'd0)
         $display("FAIL halt_exit got h=%b v=%b addr=%h want 0 0 0", halted, if_valid, imem_addr);
      else passes++;
      step();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'd0 || if_instr !== 32'd11)
         $display("FAIL halt_refetch got v=%b pc=%h instr=%0d want 1 0 11", if_valid, if_pc, if_instr);
      else passes++;
   endtask

   task automatic test_wrap();
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      checks++; if (imem_addr !== 32'h3FFF_FFFF)
         $display("FAIL wrap_addr got %h want 3fffffff", imem_addr);
      else passes++;
      step();
      checks++; if (if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0 || if_instr !== 32'h107F)
         $display("FAIL wrap_top got pc=%h pc4=%h instr=%h want fffffffc 0 107f", if_pc, if_pc_plus4, if_instr);
      else passes++;
      step();
      checks++; if (if_pc !== 32'h0 || if_instr !== 32'd11)
         $display("FAIL wrap_zero got pc=%h instr=%0d want 0 11", if_pc, if_instr);
      else passes++;
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 8; i++) step();   // BOOT + 7 fetches -> pc = 0x1C
      checks++; if (imem_addr !== 32'd7 || if_pc !== 32'h18)
         $display("FAIL pre_reset got addr=%h pc=%h want 7 18", imem_addr, if_pc);
      else passes++;
`ifdef FETCH_PERF_EN
      checks++; if (perf_fetch_cnt !== 32'd7)
         $display("FAIL perf_fetch got %0d want 7", perf_fetch_cnt);
      else passes++;
`endif
      stall = 1'b1;
      #3;
      reset = 1'b1;
      #1;
      checks++; if (imem_addr !== 32'd0 || if_pc !== 32'd0 || if_instr !== 32'd0 ||
                    if_pc_plus4 !== 32'd0 || if_valid !== 1'b0 || halted !== 1'b0 || misalign !== 1'b0)
         $display("FAIL async_reset got addr=%h pc=%h instr=%h pc4=%h v=%b h=%b m=%b want all 0",
                  imem_addr, if_pc, if_instr, if_pc_plus4, if_valid, halted, misalign);
      else passes++;
`ifdef FETCH_PERF_EN
      checks++; if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0)
         $display("FAIL perf_reset got %0d %0d want 0 0", perf_fetch_cnt, perf_stall_cnt);
      else passes++;
`endif
      stall = 1'b0;
      step();
      reset = 1'b0;
      step();
      checks++; if (if_valid !== 1'b0) $display("FAIL post_reset_boot got %b want 0", if_valid); else passes++;
   endtask

   // Guard against a hung run.
   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 32'h1000 + 32'(i);
      mem[0] = 32'd11; mem[1] = 32'd22; mem[2] = 32'd33; mem[3] = 32'd44;
      test_reset();
      test_boot_seq();
      test_stall();
      test_redirect();
      test_misalign();
      test_halt();
      test_wrap();
      test_async_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address loaded into the PC on reset.
REQ-002 Parameter IMEM_WORDS, default 128, instruction memory depth in 32-bit words.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 stall  in  1  hold PC and IF/ID outputs this cycle.
REQ-006 redirect_valid  in  1  branch/jump taken; load redirect_pc.
REQ-007 redirect_pc  in  32  target byte address.
REQ-008 halt_req  in  1  stop fetching after the current cycle.
REQ-009 imem_addr  out  32  word index to instruction memory: {2'b00, pc[31:2]}.
REQ-010 imem_rd  in  32  instruction word returned combinationally for imem_addr.
REQ-011 if_instr  out  32  registered instruction to decode.
REQ-012 if_pc  out  32  registered byte address of if_instr.
REQ-013 if_pc_plus4  out  32  registered if_pc + 4.
REQ-014 if_valid  out  1  if_instr/if_pc hold a real instruction.
REQ-015 halted  out  1  FSM in HALT.
REQ-016 misalign  out  1  sticky: a redirect target had nonzero bits [1:0].

Function
REQ-017 FSM states BOOT, RUN, HALT; BOOT -> RUN unconditionally one cycle after reset release; if_valid = 0 in BOOT.
REQ-018 RUN, no stall, no redirect: if_instr <= imem_rd, if_pc <= pc, if_pc_plus4 <= pc+4, if_valid <= 1, pc <= pc+4.
REQ-019 RUN, stall, no redirect: pc and all if_* outputs hold.
REQ-020 redirect_valid in RUN or HALT: pc <= {redirect_pc[31:2],2'b00}, if_valid <= 0 (flush), state <= RUN; redirect wins over stall and halt_req.
REQ-021 redirect_pc[1:0] != 0 sets misalign; cleared only by reset.
REQ-022 RUN, halt_req, no redirect: state <= HALT, if_valid <= 0, pc holds.
REQ-023 HALT: pc and if_* hold, if_valid = 0, stall ignored; leaves only on redirect.
REQ-024 pc+4 wraps modulo 2^32; imem_addr beyond IMEM_WORDS-1 is not checked by this block (memory aliases).
REQ-025 imem_addr is combinational from pc; fetch-to-if_valid latency is one cycle.

Reset
REQ-026 Asserting reset at any time, mid-stall or mid-redirect included, immediately forces pc = RESET_PC, state = BOOT, if_instr = 0, if_pc = 0, if_pc_plus4 = 0, if_valid = 0, halted = 0, misalign = 0.
REQ-027 With FETCH_PERF_EN defined, reset also clears perf_fetch_cnt and perf_stall_cnt to 0.

Configuration
REQ-028 Macro FETCH_PERF_EN defined: outputs perf_fetch_cnt[31:0] (+1 each cycle if_valid is loaded with 1) and perf_stall_cnt[31:0] (+1 each RUN cycle with stall and no redirect); both saturate at 32'hFFFF_FFFF.
REQ-029 FETCH_PERF_EN undefined: the perf ports and counters are absent; all other behaviour is identical.

Structure
REQ-030 Package fetch_pkg holds the fetch_state_t enum (BOOT, RUN, HALT), PC_STEP = 4, and the default RESET_PC constant.
REQ-031 Counters live in sub-module fetch_perf_ctr, instantiated only under FETCH_PERF_EN.
REQ-032 The bench pairs instr_fetch with the existing instruction memory, imem_addr driving its address and its read data returning on imem_rd.

Verification
REQ-033 Reset release, memory words 0..3 = 11,22,33,44 -> cycle 1 if_valid = 0 (BOOT); cycles 2..5 if_pc = 0,4,8,12 and if_instr = 11,22,33,44.
REQ-034 stall high 3 cycles at pc = 8 -> if_pc stays 4, imem_addr stays 2; fetch resumes at pc 8 after stall drops.
REQ-035 redirect_valid + stall together, redirect_pc = 32'h40 -> next cycle if_valid = 0, imem_addr = 16; following cycle if_pc = 32'h40.
REQ-036 redirect_pc = 32'h42 -> pc = 32'h40, misalign = 1 and stays 1 until reset.
REQ-037 halt_req -> halted = 1 and if_valid = 0 held for 10 cycles despite stall toggling; redirect to 0 -> RUN, if_pc = 0 next valid.
REQ-038 reset asserted mid-run at pc = 32'h1C -> outputs cleared asynchronously before the next clock edge; with FETCH_PERF_EN, counters read 0.
